// File: rtl/lb_uart_tx_core.sv
// Purpose: UART transmitter; start bit, 7/8 data bits LSB first, optional parity, one stop bit. Optional holding buffer via UART_TX_HOLD_BUF_EN.
// Latency: a cs sampled with ready high drives the start bit on tx from the next edge; done pulses in the last cycle of the stop bit.
// Backpressure: cs is ignored while ready is low (ready = ~busy, or holding-buffer empty when UART_TX_HOLD_BUF_EN is defined).
module lb_uart_tx_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] baud_value,
    input  logic        bit8,
    input  logic        parity_en,
    input  logic        odd_n_even,
    input  logic        cs,
    input  logic [7:0]  data_in,
    output logic        tx,
    output logic        busy,
    output logic        ready,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      r_state;
    logic [19:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_bit8;
    logic        r_par_en;
    logic        r_par_bit;
    logic        r_tx;

    // Holding buffer; only ever loaded when the buffer build option is enabled.
    logic [7:0]  r_buf_dat;
    logic        r_buf_bit8;
    logic        r_buf_par_en;
    logic        r_buf_odd;
    logic        r_buf_vld;

    logic [19:0] w_baud;
    logic        w_bit_end;
    logic        w_accept;
    logic        w_stop_end;
    logic        w_from_buf;
    logic        w_start;
    logic        w_launch;
    logic [2:0]  w_last_idx;
    logic [7:0]  w_src_dat;
    logic        w_src_bit8;
    logic        w_src_par_en;
    logic        w_src_odd;
    logic [7:0]  w_src_mask;
    logic        w_src_par;

`ifdef UART_TX_HOLD_BUF_EN
    localparam logic LP_HOLD_BUF = 1'b1;
    assign ready = ~r_buf_vld;
`else
    localparam logic LP_HOLD_BUF = 1'b0;
    assign ready = ~busy;
`endif

    // A zero bit period behaves as a one-cycle period.
    assign w_baud     = (baud_value == 20'd0) ? 20'd1 : baud_value;
    assign w_bit_end  = (r_baud_cnt <= 20'd1);
    assign w_accept   = cs & ready;
    assign w_stop_end = (r_state == STOP) && w_bit_end;
    // A buffered frame takes priority at stop end; a fresh cs can only arrive then if the buffer is empty.
    assign w_from_buf = w_stop_end & r_buf_vld;
    assign w_start    = w_accept && ((r_state == IDLE) || w_stop_end);
    assign w_launch   = w_start | w_from_buf;
    assign w_last_idx = r_bit8 ? 3'd7 : 3'd6;

    assign w_src_dat    = w_from_buf ? r_buf_dat    : data_in;
    assign w_src_bit8   = w_from_buf ? r_buf_bit8   : bit8;
    assign w_src_par_en = w_from_buf ? r_buf_par_en : parity_en;
    assign w_src_odd    = w_from_buf ? r_buf_odd    : odd_n_even;
    assign w_src_mask   = w_src_bit8 ? 8'hFF : 8'h7F;
    // odd_n_even=1 makes the total ones over data+parity even.
    assign w_src_par    = (^(w_src_dat & w_src_mask)) ^ ~w_src_odd;

    assign tx   = r_tx;
    assign busy = (r_state != IDLE);
    assign done = w_stop_end;

    // Frame sequencer: bit timing, data shifting, holding buffer and the tx line register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_baud_cnt   <= 20'd0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
            r_bit8       <= 1'b0;
            r_par_en     <= 1'b0;
            r_par_bit    <= 1'b0;
            r_tx         <= 1'b1;
            r_buf_dat    <= 8'd0;
            r_buf_bit8   <= 1'b0;
            r_buf_par_en <= 1'b0;
            r_buf_odd    <= 1'b0;
            r_buf_vld    <= 1'b0;
        end else begin
            if (LP_HOLD_BUF && w_accept && !w_start) begin
                r_buf_dat    <= data_in;
                r_buf_bit8   <= bit8;
                r_buf_par_en <= parity_en;
                r_buf_odd    <= odd_n_even;
                r_buf_vld    <= 1'b1;
            end else if (w_from_buf) begin
                r_buf_vld    <= 1'b0;
            end

            if (w_launch) begin
                r_state    <= START;
                r_tx       <= 1'b0;
                r_baud_cnt <= w_baud;
                r_bit_idx  <= 3'd0;
                r_shift    <= w_src_dat;
                r_bit8     <= w_src_bit8;
                r_par_en   <= w_src_par_en;
                r_par_bit  <= w_src_par;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_tx <= 1'b1;
                    end
                    START: begin
                        if (w_bit_end) begin
                            r_state    <= DATA;
                            r_tx       <= r_shift[0];
                            r_baud_cnt <= w_baud;
                            r_bit_idx  <= 3'd0;
                        end else begin
                            r_baud_cnt <= r_baud_cnt - 20'd1;
                        end
                    end
                    DATA: begin
                        if (w_bit_end) begin
                            r_baud_cnt <= w_baud;
                            if (r_bit_idx == w_last_idx) begin
                                if (r_par_en) begin
                                    r_state <= PARITY;
                                    r_tx    <= r_par_bit;
                                end else begin
                                    r_state <= STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                                r_shift   <= r_shift >> 1;
                                r_tx      <= r_shift[1];
                            end
                        end else begin
                            r_baud_cnt <= r_baud_cnt - 20'd1;
                        end
                    end
                    PARITY: begin
                        if (w_bit_end) begin
                            r_state    <= STOP;
                            r_tx       <= 1'b1;
                            r_baud_cnt <= w_baud;
                        end else begin
                            r_baud_cnt <= r_baud_cnt - 20'd1;
                        end
                    end
                    STOP: begin
                        if (w_bit_end) begin
                            r_state    <= IDLE;
                            r_tx       <= 1'b1;
                            r_baud_cnt <= 20'd0;
                        end else begin
                            r_baud_cnt <= r_baud_cnt - 20'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lb_uart_tx_core.sv
// Purpose: self-checking bench for lb_uart_tx_core against a per-cycle waveform model built from frame rules.
// Latency: expects tx low and busy high on the cycle after the edge that samples cs.
// Backpressure: checks ready/cs interaction with and without UART_TX_HOLD_BUF_EN.
module tb_lb_uart_tx_core;
    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] baud_value;
    logic        bit8;
    logic        parity_en;
    logic        odd_n_even;
    logic        cs;
    logic [7:0]  data_in;
    logic        tx;
    logic        busy;
    logic        ready;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected per-cycle line value and done flag, one entry per clock cycle.
    logic exp_tx[$];
    logic exp_done[$];

    always #5 clk = ~clk;

    lb_uart_tx_core u_dut (
        .clk        (clk),
        .reset      (reset),
        .baud_value (baud_value),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .cs         (cs),
        .data_in    (data_in),
        .tx         (tx),
        .busy       (busy),
        .ready      (ready),
        .done       (done)
    );

    // Reference model: list the frame's bits, then stretch each one to the bit period.
    task automatic model_frame(input logic [7:0] d, input logic b8, input logic pen,
                               input logic odd, input int baud);
        int   nb;
        int   eb;
        int   ones;
        logic bits[$];
        nb   = b8 ? 8 : 7;
        eb   = (baud == 0) ? 1 : baud;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pen) begin
            if (odd) bits.push_back((ones % 2) == 1);
            else     bits.push_back((ones % 2) == 0);
        end
        bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int c = 0; c < eb; c++) begin
                exp_tx.push_back(bits[b]);
                exp_done.push_back(1'b0);
            end
        end
        exp_done[exp_done.size() - 1] = 1'b1;
    endtask

    // Pulse cs for one cycle, then scramble the config inputs to prove they were latched.
    task automatic drive_cs(input logic [7:0] d, input logic b8, input logic pen, input logic odd);
        @(negedge clk);
        data_in = d; bit8 = b8; parity_en = pen; odd_n_even = odd; cs = 1'b1;
        @(negedge clk);
        cs         = 1'b0;
        data_in    = 8'($urandom);
        bit8       = 1'($urandom_range(0, 1));
        parity_en  = 1'($urandom_range(0, 1));
        odd_n_even = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset;
        reset = 1'b1; cs = 1'b1; data_in = 8'hA5; baud_value = 20'd4;
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b ready=%b, want 1 0 0 1", tx, busy, done, ready);
        end
        reset = 1'b0; cs = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: tx=%b busy=%b done=%b, want 1 0 0", tx, busy, done);
        end
    endtask

    task automatic test_8n1_55;
        int done_cnt;
        int done_at;
        exp_tx.delete(); exp_done.delete();
        baud_value = 20'd4;
        model_frame(8'h55, 1'b1, 1'b0, 1'b1, 4);
        drive_cs(8'h55, 1'b1, 1'b0, 1'b1);
        done_cnt = 0; done_at = -1;
        for (int k = 0; k < exp_tx.size(); k++) begin
            n_checks++;
            if (tx !== exp_tx[k] || done !== exp_done[k] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL 8n1_55 cyc %0d: tx=%b done=%b busy=%b, want %b %b 1", k, tx, done, busy, exp_tx[k], exp_done[k]);
            end
            if (done === 1'b1) begin done_cnt++; done_at = k; end
            @(negedge clk);
        end
        n_checks++;
        if (done_cnt != 1 || done_at != 39) begin
            n_fail++;
            $display("FAIL 8n1_55_done: count=%0d at=%0d, want 1 at 39", done_cnt, done_at);
        end
        n_checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL 8n1_55_end: busy=%b tx=%b ready=%b, want 0 1 1", busy, tx, ready);
        end
    endtask

    task automatic test_parity;
        for (int p = 1; p >= 0; p--) begin
            exp_tx.delete(); exp_done.delete();
            baud_value = 20'd2;
            model_frame(8'h07, 1'b1, 1'b1, 1'(p), 2);
            drive_cs(8'h07, 1'b1, 1'b1, 1'(p));
            for (int k = 0; k < exp_tx.size(); k++) begin
                n_checks++;
                if (tx !== exp_tx[k] || done !== exp_done[k] || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL parity_07 odd_n_even=%0d cyc %0d: tx=%b done=%b busy=%b, want %b %b 1", p, k, tx, done, busy, exp_tx[k], exp_done[k]);
                end
                if (k == 18) begin
                    n_checks++;
                    if (tx !== 1'(p)) begin
                        n_fail++;
                        $display("FAIL parity_bit_07 odd_n_even=%0d: tx=%b, want %0d", p, tx, p);
                    end
                end
                @(negedge clk);
            end
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL parity_len odd_n_even=%0d: busy=%b after 22 cycles, want 0", p, busy);
            end
        end
    endtask

    task automatic test_7bit_parity;
        exp_tx.delete(); exp_done.delete();
        baud_value = 20'd3;
        model_frame(8'h81, 1'b0, 1'b1, 1'b1, 3);
        drive_cs(8'h81, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < exp_tx.size(); k++) begin
            n_checks++;
            if (tx !== exp_tx[k] || done !== exp_done[k] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL 7bit_81 cyc %0d: tx=%b done=%b busy=%b, want %b %b 1", k, tx, done, busy, exp_tx[k], exp_done[k]);
            end
            if (k == 22) begin
                n_checks++;
                if (tx !== 1'b0) begin
                    n_fail++;
                    $display("FAIL 7bit_81_bit6: tx=%b, want 0", tx);
                end
            end
            if (k == 25) begin
                n_checks++;
                if (tx !== 1'b1) begin
                    n_fail++;
                    $display("FAIL 7bit_81_parity: tx=%b, want 1", tx);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL 7bit_81_len: busy=%b tx=%b after 30 cycles, want 0 1", busy, tx);
        end
    endtask

    task automatic test_baud0;
        logic [7:0] d;
        int         busy_cyc;
        exp_tx.delete(); exp_done.delete();
        d = 8'($urandom);
        baud_value = 20'd0;
        model_frame(d, 1'b1, 1'b0, 1'b1, 0);
        drive_cs(d, 1'b1, 1'b0, 1'b1);
        busy_cyc = 0;
        for (int k = 0; k < 20; k++) begin
            if (k < exp_tx.size()) begin
                n_checks++;
                if (tx !== exp_tx[k] || done !== exp_done[k]) begin
                    n_fail++;
                    $display("FAIL baud0 cyc %0d: tx=%b done=%b, want %b %b", k, tx, done, exp_tx[k], exp_done[k]);
                end
            end
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (busy_cyc != 10) begin
            n_fail++;
            $display("FAIL baud0_len: busy cycles=%0d, want 10", busy_cyc);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] da;
        logic [7:0] db;
        logic       pa;
        logic       pb;
        int         done_cnt;
        int         want_done;
        exp_tx.delete(); exp_done.delete();
        da = 8'($urandom); db = 8'($urandom);
        pa = 1'($urandom_range(0, 1)); pb = 1'($urandom_range(0, 1));
        baud_value = 20'd2;
        model_frame(da, 1'b1, pa, 1'b1, 2);
`ifdef UART_TX_HOLD_BUF_EN
        model_frame(db, 1'b1, pb, 1'b0, 2);
        want_done = 2;
`else
        want_done = 1;
`endif
        drive_cs(da, 1'b1, pa, 1'b1);
        done_cnt = 0;
        for (int k = 0; k < exp_tx.size(); k++) begin
            n_checks++;
            if (tx !== exp_tx[k] || done !== exp_done[k] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: tx=%b done=%b busy=%b, want %b %b 1", k, tx, done, busy, exp_tx[k], exp_done[k]);
            end
            if (done === 1'b1) done_cnt++;
            if (k == 6) begin
                n_checks++;
`ifdef UART_TX_HOLD_BUF_EN
                if (ready !== 1'b1) begin
`else
                if (ready !== 1'b0) begin
`endif
                    n_fail++;
                    $display("FAIL b2b_ready: ready=%b while busy with buffer option %0d", ready, want_done - 1);
                end
                data_in = db; bit8 = 1'b1; parity_en = pb; odd_n_even = 1'b0; cs = 1'b1;
            end
            if (k == 7) cs = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_tail cyc %0d: tx=%b busy=%b done=%b, want 1 0 0", k, tx, busy, done);
            end
            @(negedge clk);
        end
        n_checks++;
        if (done_cnt != want_done) begin
            n_fail++;
            $display("FAIL b2b_done_count: %0d, want %0d", done_cnt, want_done);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        exp_tx.delete(); exp_done.delete();
        d = 8'($urandom);
        baud_value = 20'd3;
        model_frame(d, 1'b1, 1'b0, 1'b1, 3);
        drive_cs(d, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 13; k++) begin
            n_checks++;
            if (tx !== exp_tx[k] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_mid_pre cyc %0d: tx=%b busy=%b, want %b 1", k, tx, busy, exp_tx[k]);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_abort: tx=%b busy=%b done=%b ready=%b, want 1 0 0 1", tx, busy, done, ready);
        end
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            n_checks++;
            if (tx !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_quiet cyc %0d: tx=%b done=%b busy=%b, want 1 0 0", k, tx, done, busy);
            end
            @(negedge clk);
        end
        exp_tx.delete(); exp_done.delete();
        d = 8'($urandom);
        model_frame(d, 1'b1, 1'b1, 1'b0, 3);
        drive_cs(d, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < exp_tx.size(); k++) begin
            n_checks++;
            if (tx !== exp_tx[k] || done !== exp_done[k] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_mid_clean cyc %0d: tx=%b done=%b busy=%b, want %b %b 1", k, tx, done, busy, exp_tx[k], exp_done[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic       b8;
        logic       pen;
        logic       odd;
        int         baud;
        for (int f = 0; f < 25; f++) begin
            exp_tx.delete(); exp_done.delete();
            d    = 8'($urandom);
            b8   = 1'($urandom_range(0, 1));
            pen  = 1'($urandom_range(0, 1));
            odd  = 1'($urandom_range(0, 1));
            baud = int'($urandom_range(0, 5));
            baud_value = 20'(baud);
            model_frame(d, b8, pen, odd, baud);
            drive_cs(d, b8, pen, odd);
            for (int k = 0; k < exp_tx.size(); k++) begin
                n_checks++;
                if (tx !== exp_tx[k] || done !== exp_done[k] || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL random f%0d d=%02h b8=%b pen=%b odd=%b baud=%0d cyc %0d: tx=%b done=%b busy=%b, want %b %b 1",
                             f, d, b8, pen, odd, baud, k, tx, done, busy, exp_tx[k], exp_done[k]);
                end
                @(negedge clk);
            end
            n_checks++;
            if (busy !== 1'b0 || tx !== 1'b1 || ready !== 1'b1) begin
                n_fail++;
                $display("FAIL random_end f%0d: busy=%b tx=%b ready=%b, want 0 1 1", f, busy, tx, ready);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; data_in = 8'h00; baud_value = 20'd4;
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b1;
        test_reset();
        test_8n1_55();
        test_parity();
        test_7bit_parity();
        test_baud0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lb_uart_tx_core.md
LB_UART_TX_CORE -- requirements
Module: lb_uart_tx_core

Interface
REQ-001 The block SHALL have no parameters; all configuration comes from ports.
REQ-002 The block SHALL use one clock: clk, input, 1 bit, system clock, all logic on its rising edge.
REQ-003 The block SHALL have reset: input, 1 bit, synchronous, active-high.
REQ-004 baud_value  input  20  bit period in clk cycles; 0 SHALL be treated as 1.
REQ-005 bit8  input  1  1 = 8 data bits, 0 = 7 data bits (data_in[6:0]).
REQ-006 parity_en  input  1  1 = parity bit appended after data.
REQ-007 odd_n_even  input  1  1 = even total ones over data+parity, 0 = odd.
REQ-008 cs  input  1  load strobe, one-cycle request to send data_in.
REQ-009 data_in  input  8  byte to transmit.
REQ-010 tx  output  1  serial line, idle high, registered.
REQ-011 busy  output  1  high while a frame is on the line.
REQ-012 ready  output  1  high when cs will be accepted this cycle.
REQ-013 done  output  1  one-cycle pulse at end of each stop bit.

Function
REQ-014 Frame SHALL be: start (0), data LSB first (7 or 8 bits), optional parity, one stop (1).
REQ-015 Each bit SHALL hold tx for exactly baud_value cycles (baud counter 20 bits, counts down to 1).
REQ-016 cs with ready high SHALL latch data_in, bit8, parity_en and odd_n_even; later config changes SHALL NOT affect the frame in flight.
REQ-017 cs with ready low SHALL be ignored, with no state change.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP: IDLE->START on accept; START->DATA after one bit period; DATA->PARITY (parity_en) or STOP after the last data bit; PARITY->STOP; STOP->IDLE, or STOP->START if a frame is pending.
REQ-019 Accept at edge N SHALL drive tx low from edge N+1; busy SHALL rise at N+1.
REQ-020 Parity SHALL be XOR of the transmitted data bits, inverted when odd_n_even=0.
REQ-021 done SHALL pulse in the last cycle of STOP; busy SHALL fall the next cycle unless a pending frame starts.
REQ-022 Total frame length SHALL be baud_value x (1 + 7/8 + parity_en + 1) cycles.

Reset
REQ-023 Reset SHALL force IDLE, tx=1, busy=0, done=0, ready=1, counters=0, and pending buffer empty.
REQ-024 Reset mid-frame SHALL abort the frame; tx=1 from the next edge, and no done pulse.

Configuration
REQ-025 Macro UART_TX_HOLD_BUF_EN defined: a one-entry holding buffer is added; ready = buffer empty; a frame accepted while busy SHALL start (START state, tx low) in the cycle right after the previous stop bit ends, with no idle cycle.
REQ-026 Macro undefined: no buffer; ready = ~busy; there is at least one idle-high cycle between frames.

Verification
REQ-027 baud_value=4, 8N1, data_in=0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; done pulses once, 40 cycles after the tx falling edge minus 1.
REQ-028 8-bit, parity_en=1, odd_n_even=1, data_in=0x07 -> parity bit 1; repeat with odd_n_even=0 -> parity bit 0; frame 11 bit periods.
REQ-029 bit8=0, parity_en=1, odd_n_even=1, data_in=0x81 -> 7 data bits 1,0,0,0,0,0,0, then parity 1, then stop; bit 7 is never sent.
REQ-030 cs pulsed while busy, macro undefined -> ignored, single frame; macro defined -> second frame's start bit immediately follows the first stop bit, with two done pulses.
REQ-031 reset asserted during DATA bit 3 -> tx=1, busy=0 next cycle; no done; new cs afterwards sends a clean frame.
REQ-032 baud_value=0 -> each bit lasts 1 cycle; 8N1 frame lasts 10 cycles.
